// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, the four control tokens,
// the aligner state encoding and the symbol decode helpers.
package tmds_pkg;

  localparam int unsigned TMDS_SYM_W = 10;

  // Control tokens, indexed by {c1,c0}.
  localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  // True when the symbol is one of the four control tokens.
  function automatic logic tmds_is_ctrl(input logic [TMDS_SYM_W-1:0] sym);
    return (sym == TMDS_CTRL_00) || (sym == TMDS_CTRL_01) ||
           (sym == TMDS_CTRL_10) || (sym == TMDS_CTRL_11);
  endfunction

  // {c1,c0} carried by a control token; 00 for anything else.
  function automatic logic [1:0] tmds_ctrl_bits(input logic [TMDS_SYM_W-1:0] sym);
    logic [1:0] bits;
    bits = 2'b00;
    case (sym)
      TMDS_CTRL_01: bits = 2'b01;
      TMDS_CTRL_10: bits = 2'b10;
      TMDS_CTRL_11: bits = 2'b11;
      default:      bits = 2'b00;
    endcase
    return bits;
  endfunction

  // Undo the DC-balance inversion (bit 9), then the XOR/XNOR
  // transition chain selected by bit 8.
  function automatic logic [7:0] tmds_decode(input logic [TMDS_SYM_W-1:0] sym);
    logic [7:0] q;
    logic [7:0] d;
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Symbol-alignment FSM: SEARCH finds the lowest offset carrying a control
// token, VERIFY demands LOCK_COUNT consecutive tokens at that offset, LOCKED
// holds alignment until TIMEOUT_CYCLES non-token symbols pass without a token.
// The current state is exposed on state_o for observation.
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT     = 8,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [TMDS_SYM_W-1:0] tok_vec_i,     // token match per offset
  output align_state_e          state_o,
  output logic [3:0]            offset_o,
  output logic                  locked_o,
  output logic                  tok_held_o,    // token at the held offset
  output logic                  verify_done_o, // last token of the lock run
  output logic                  timeout_hit_o  // lock drops this cycle
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_COUNT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  align_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    offset_q, offset_d;
  logic [TW-1:0] timeout_q, timeout_d, timeout_inc;
  logic          locked_q;
  logic          tok_held, verify_done, timeout_hit;

  // State, counters and offset registers; locked mirrors the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_SEARCH;
      cnt_q     <= '0;
      offset_q  <= '0;
      timeout_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset_d;
      timeout_q <= timeout_d;
      locked_q  <= (state_d == ST_LOCKED);
    end
  end

  // Next state: a token in the timeout cycle clears the counter first.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    offset_d  = offset_q;
    timeout_d = '0;
    unique case (state_q)
      ST_SEARCH: begin
        cnt_d = '0;
        if (|tok_vec_i) begin
          for (int k = TMDS_SYM_W - 1; k >= 0; k--) begin
            if (tok_vec_i[k]) offset_d = 4'(k);
          end
          cnt_d   = CW'(1);
          state_d = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (tok_held) begin
          cnt_d = cnt_q + 1'b1;
          if (verify_done) state_d = ST_LOCKED;
        end else begin
          cnt_d   = '0;
          state_d = ST_SEARCH;
        end
      end
      ST_LOCKED: begin
        if (!tok_held) begin
          timeout_d = timeout_inc;
          if (timeout_hit) begin
            timeout_d = '0;
            cnt_d     = '0;
            state_d   = ST_SEARCH;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SEARCH;
      end
    endcase
  end

  // Decision strobes shared with the data path.
  always_comb begin
    tok_held    = tok_vec_i[offset_q];
    timeout_inc = (timeout_q == TMO_MAX) ? timeout_q : timeout_q + 1'b1;
    verify_done = (state_q == ST_VERIFY) && tok_held && (cnt_q == CNT_LAST);
    timeout_hit = (state_q == ST_LOCKED) && !tok_held && (timeout_inc == TMO_MAX);
  end

  assign state_o       = state_q;
  assign offset_o      = offset_q;
  assign locked_o      = locked_q;
  assign tok_held_o    = tok_held;
  assign verify_done_o = verify_done;
  assign timeout_hit_o = timeout_hit;

endmodule

// File: rtl/tmds_rx_decoder.sv
// One TMDS receive channel: aligns unaligned 10-bit words on control tokens
// and decodes symbols to pixel data, control bits and display enable.
// One word is accepted every pixelClock; there is no flow control.
// Optional TMDS_RX_POS_COUNT_EN adds hPos/vPos counters; otherwise both are 0.
module tmds_rx_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT     = 8,
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int H_WIDTH        = 11,
  parameter int V_WIDTH        = 10
) (
  input  logic               pixelClock,
  input  logic               reset_n,
  input  logic [9:0]         wordIn,
  output logic [7:0]         dataOut,
  output logic [1:0]         ctrlOut,
  output logic               de,
  output logic               locked,
  output logic [3:0]         alignOffset,
  output logic [H_WIDTH-1:0] hPos,
  output logic [V_WIDTH-1:0] vPos
);

  logic [TMDS_SYM_W-1:0]   prev_word_q;
  logic [2*TMDS_SYM_W-1:0] window;
  logic [TMDS_SYM_W-1:0]   tok_vec;
  logic [TMDS_SYM_W-1:0]   sym;
  align_state_e            align_state;
  logic [3:0]              offset;
  logic                    tok_held, verify_done, timeout_hit;
  logic                    data_load, ctrl_load;
  logic [7:0]              data_q, data_d;
  logic [1:0]              ctrl_q, ctrl_d;
  logic                    de_q, de_d;

  // Candidate symbols at all ten offsets and the one at the held offset.
  always_comb begin
    window = {wordIn, prev_word_q};
    for (int k = 0; k < TMDS_SYM_W; k++) begin
      tok_vec[k] = tmds_is_ctrl(window[k +: TMDS_SYM_W]);
    end
    sym = TMDS_SYM_W'(window >> offset);
  end

  tmds_align_fsm #(
    .LOCK_COUNT    (LOCK_COUNT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_align (
    .clk_i        (pixelClock),
    .rst_ni       (reset_n),
    .tok_vec_i    (tok_vec),
    .state_o      (align_state),
    .offset_o     (offset),
    .locked_o     (locked),
    .tok_held_o   (tok_held),
    .verify_done_o(verify_done),
    .timeout_hit_o(timeout_hit)
  );

  // Output next values: tokens update ctrl (also on the locking token), data decodes.
  always_comb begin
    ctrl_load = tok_held && ((align_state == ST_LOCKED) || verify_done);
    data_load = (align_state == ST_LOCKED) && !tok_held && !timeout_hit;
    de_d      = data_load;
    data_d    = data_load ? tmds_decode(sym) : 8'h00;
    ctrl_d    = ctrl_load ? tmds_ctrl_bits(sym) : ctrl_q;
  end

  // Word history and registered outputs.
  always_ff @(posedge pixelClock or negedge reset_n) begin
    if (!reset_n) begin
      prev_word_q <= '0;
      data_q      <= '0;
      ctrl_q      <= '0;
      de_q        <= 1'b0;
    end else begin
      prev_word_q <= wordIn;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      de_q        <= de_d;
    end
  end

  assign dataOut     = data_q;
  assign ctrlOut     = ctrl_q;
  assign de          = de_q;
  assign alignOffset = offset;

`ifdef TMDS_RX_POS_COUNT_EN
  logic [H_WIDTH-1:0] hpos_q, hpos_d;
  logic [V_WIDTH-1:0] vpos_q, vpos_d;

  // hPos counts data cycles of a line; vPos counts lines, cleared by vSync rising.
  always_comb begin
    hpos_d = de_d ? (de_q ? hpos_q + 1'b1 : '0) : '0;
    vpos_d = vpos_q;
    if (de_q && !de_d)        vpos_d = vpos_q + 1'b1;
    if (ctrl_d[1] && !ctrl_q[1]) vpos_d = '0;
  end

  // Position counter registers.
  always_ff @(posedge pixelClock or negedge reset_n) begin
    if (!reset_n) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  assign hPos = hpos_q;
  assign vPos = vpos_q;
`else
  assign hPos = '0;
  assign vPos = '0;
`endif

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: directed lock/decode/timeout scenarios plus
// randomized token/data streams at random bit rotations, all checked against
// a behavioural model of alignment and decoding.
module tb_tmds_rx_decoder;

  localparam int LOCK_COUNT     = 8;
  localparam int TIMEOUT_CYCLES = 2048;
  localparam int H_WIDTH        = 11;
  localparam int V_WIDTH        = 10;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic               pixelClock = 1'b0;
  logic               reset_n    = 1'b0;
  logic [9:0]         wordIn     = '0;
  logic [7:0]         dataOut;
  logic [1:0]         ctrlOut;
  logic               de;
  logic               locked;
  logic [3:0]         alignOffset;
  logic [H_WIDTH-1:0] hPos;
  logic [V_WIDTH-1:0] vPos;

  int checks = 0;
  int errors = 0;

  logic [9:0] toks [4];

  // Behavioural model state.
  logic [9:0] m_prev;
  bit         m_locked;
  int         m_run;   // consecutive tokens at m_off while not locked; 0 = searching
  int         m_idle;  // non-token symbols since the last token while locked
  int         m_off;
  logic [1:0] m_ctrl;
  bit         m_de;
  logic [7:0] m_data;
  int         m_h, m_v;

  tmds_rx_decoder #(
    .LOCK_COUNT    (LOCK_COUNT),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .H_WIDTH       (H_WIDTH),
    .V_WIDTH       (V_WIDTH)
  ) dut (
    .pixelClock (pixelClock),
    .reset_n    (reset_n),
    .wordIn     (wordIn),
    .dataOut    (dataOut),
    .ctrlOut    (ctrlOut),
    .de         (de),
    .locked     (locked),
    .alignOffset(alignOffset),
    .hPos       (hPos),
    .vPos       (vPos)
  );

  // Clock.
  always #5 pixelClock = ~pixelClock;

  // Watchdog.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int tok_index(input logic [9:0] s);
    for (int c = 0; c < 4; c++) if (s == toks[c]) return c;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] q, o;
    q    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = q[0];
    for (int i = 1; i < 8; i++) o[i] = ((q[i] ^ q[i-1]) == s[8]);
    return o;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_locked = 0; m_run = 0; m_idle = 0; m_off = 0;
    m_ctrl = '0; m_de = 0; m_data = '0; m_h = 0; m_v = 0;
  endtask

  // Expected outputs after the edge that samples word w.
  task automatic model_step(input logic [9:0] w);
    logic [19:0] win;
    logic [9:0]  s;
    int          ti, first;
    bit          old_de;
    logic [1:0]  old_ctrl;
    win      = {w, m_prev};
    old_de   = m_de;
    old_ctrl = m_ctrl;
    s        = 10'(win >> m_off);
    ti       = tok_index(s);
    m_de     = 0;
    m_data   = '0;
    if (m_locked) begin
      if (ti >= 0) begin
        m_idle = 0;
        m_ctrl = 2'(ti);
      end else begin
        m_idle++;
        if (m_idle >= TIMEOUT_CYCLES) begin
          m_locked = 0; m_idle = 0; m_run = 0;
        end else begin
          m_de = 1; m_data = ref_decode(s);
        end
      end
    end else if (m_run == 0) begin
      first = -1;
      for (int k = 9; k >= 0; k--) if (tok_index(10'(win >> k)) >= 0) first = k;
      if (first >= 0) begin m_off = first; m_run = 1; end
    end else if (ti >= 0) begin
      m_run++;
      if (m_run == LOCK_COUNT) begin m_locked = 1; m_ctrl = 2'(ti); m_run = 0; end
    end else begin
      m_run = 0;
    end
`ifdef TMDS_RX_POS_COUNT_EN
    if (m_de) m_h = old_de ? (m_h + 1) % (1 << H_WIDTH) : 0;
    else      m_h = 0;
    if (old_de && !m_de) m_v = (m_v + 1) % (1 << V_WIDTH);
    if (m_ctrl[1] && !old_ctrl[1]) m_v = 0;
`else
    old_de   = old_de;
    old_ctrl = old_ctrl;
`endif
    m_prev = w;
  endtask

  task automatic check_all();
    check("locked", locked, m_locked);
    check("offset", alignOffset, m_off);
    check("de", de, m_de);
    check("data", dataOut, m_data);
    check("ctrl", ctrlOut, m_ctrl);
    check("hpos", hPos, m_h);
    check("vpos", vPos, m_v);
  endtask

  // Driver: present one word, clock it, compare.
  task automatic step(input logic [9:0] w);
    wordIn = w;
    model_step(w);
    @(posedge pixelClock);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wordIn  = '0;
    #3;
    check("rst_locked", locked, 0);
    check("rst_offset", alignOffset, 0);
    check("rst_de", de, 0);
    check("rst_data", dataOut, 0);
    check("rst_ctrl", ctrlOut, 0);
    check("rst_hpos", hPos, 0);
    check("rst_vpos", vPos, 0);
    model_reset();
    repeat (2) @(posedge pixelClock);
    #1;
    reset_n = 1'b1;
  endtask

  // Symbols serialized LSB first after rot leading zeros, cut into words.
  task automatic send_stream(input int rot, input int nsym, input int tok_pct, input int fixed_tok);
    bit         bq[$];
    logic [9:0] s, w;
    for (int i = 0; i < rot; i++) bq.push_back(1'b0);
    for (int n = 0; n < nsym; n++) begin
      if (fixed_tok >= 0) s = toks[fixed_tok];
      else if ($urandom_range(0, 99) < tok_pct) s = toks[$urandom_range(0, 3)];
      else s = 10'($urandom_range(0, 1023));
      for (int b = 0; b < 10; b++) bq.push_back(s[b]);
    end
    while (bq.size() >= 10) begin
      for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
      step(w);
    end
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    if (tok_index(w) >= 0) w = 10'h100;
    return w;
  endfunction

  initial begin
    int hmax;
    toks[0] = TOK00; toks[1] = TOK01; toks[2] = TOK10; toks[3] = TOK11;
    model_reset();
    @(posedge pixelClock);
    #1;

    // Lock at offset 0 on token 00.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(TOK00);
      check("t1_lock", locked, (i >= 9));
    end
    check("t1_offset", alignOffset, 0);
    check("t1_ctrl", ctrlOut, 2'b00);
    check("t1_de", de, 0);

    // Decode two data symbols, each two edges after its word.
    step(10'h100);
    step(10'h2FF);
    check("t3_de_a", de, 1);
    check("t3_data_a", dataOut, 8'h00);
    step(TOK00);
    check("t3_de_b", de, 1);
    check("t3_data_b", dataOut, 8'hFE);
    step(TOK00);
    check("t3_de_c", de, 0);

    // Random tokens and data while locked.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) step(toks[$urandom_range(0, 3)]);
      else step(10'($urandom_range(0, 1023)));
    end

    // Timeout after TIMEOUT_CYCLES data symbols.
    for (int i = 0; i < 10; i++) step(TOK00);
    check("t5_pre", locked, 1);
    for (int i = 1; i <= TIMEOUT_CYCLES; i++) step(10'h100);
    check("t5_hold", locked, 1);
    step(10'h100);
    check("t5_drop", locked, 0);
    check("t5_drop_de", de, 0);
    // A token in the final cycle keeps lock.
    for (int i = 0; i < 10; i++) step(TOK00);
    check("t5_relock", locked, 1);
    for (int i = 1; i < TIMEOUT_CYCLES; i++) step(10'h100);
    step(TOK00);
    step(TOK00);
    check("t5_keep", locked, 1);

    // Broken verify run, then a full run.
    do_reset();
    for (int i = 0; i < 5; i++) step(TOK00);
    step(10'h100);
    for (int i = 0; i < 8; i++) step(TOK00);
    check("t4_pre", locked, 0);
    step(TOK00);
    check("t4_lock", locked, 1);

    // Token 01 stream rotated by 3 bits.
    do_reset();
    send_stream(3, 13, 0, 1);
    check("t2_lock", locked, 1);
    check("t2_offset", alignOffset, 3);
    check("t2_ctrl", ctrlOut, 2'b01);

    // Random rotations and mixed token/data streams.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      send_stream(int'($urandom_range(0, 9)), 12, 100, -1);
      send_stream(0, 40, 60, -1);
    end

    // Lines framed by vSync and token 00, then reset mid-line.
    do_reset();
    for (int i = 0; i < 10; i++) step(TOK00);
    step(TOK10);
    step(TOK10);
    check("t6_vsync_ctrl", ctrlOut, 2'b10);
    check("t6_vsync_v", vPos, 0);
    for (int ln = 0; ln < 3; ln++) begin
      hmax = 0;
      for (int i = 0; i < 4; i++) begin
        step(rand_data());
        if (de && int'(hPos) > hmax) hmax = int'(hPos);
      end
      for (int i = 0; i < 3; i++) begin
        step(TOK00);
        if (de && int'(hPos) > hmax) hmax = int'(hPos);
      end
`ifdef TMDS_RX_POS_COUNT_EN
      check("t6_hmax", hmax, 3);
      check("t6_vpos", vPos, ln + 1);
`else
      check("t6_hmax", hmax, 0);
`endif
    end
    step(rand_data());
    step(rand_data());
    step(rand_data());
    check("t6_midline_de", de, 1);
    do_reset();
    for (int i = 0; i < 8; i++) step(TOK00);
    check("t6_post_rst", locked, 0);
    step(TOK00);
    check("t6_relock", locked, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
